// File: rtl/trig_rom_arbiter.sv
// Arbitrates the shared sine/cosine ROM among render, player and opponent physics.
// Angle requests enter over valid/ready. A one-hot tag pipeline routes each ROM result back to its requester.
module trig_rom_arbiter #(
    parameter int unsigned ANGLE_W   = 9,
    parameter int unsigned TRIG_W    = 11,
    parameter int unsigned ANGLE_MAX = 359,
    parameter int unsigned ROM_LAT   = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [2:0]                 req_valid_in,
    input  logic [3*ANGLE_W-1:0]       req_angle_in,
    output logic [2:0]                 req_ready_out,
    output logic [2:0]                 rsp_valid_out,
    output logic signed [TRIG_W-1:0]   rsp_cos_out,
    output logic signed [TRIG_W-1:0]   rsp_sin_out,
    output logic [ANGLE_W-1:0]         rom_addr_out,
    input  logic signed [TRIG_W-1:0]   rom_cos_in,
    input  logic signed [TRIG_W-1:0]   rom_sin_in
);

    typedef enum logic {
        RR_PLAYER   = 1'b0,
        RR_OPPONENT = 1'b1
    } rr_e;

    rr_e                      rr_q, rr_d;
    logic [2:0]               grant;
    logic [ANGLE_W-1:0]       sel_angle;
    logic [ANGLE_W-1:0]       norm_angle;
    logic [ANGLE_W-1:0]       addr_q, addr_d;
    logic [2:0]               tag_q [ROM_LAT+1];
    logic [2:0]               tag_d [ROM_LAT+1];
    logic [2:0]               rsp_valid_q, rsp_valid_d;
    logic signed [TRIG_W-1:0] rsp_cos_q, rsp_cos_d;
    logic signed [TRIG_W-1:0] rsp_sin_q, rsp_sin_d;

    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        if (req_valid_in[0]) begin
            grant = 3'b001;
        end else if (req_valid_in[1] && req_valid_in[2]) begin
            grant = (rr_q == RR_PLAYER) ? 3'b010 : 3'b100;
        end else if (req_valid_in[1]) begin
            grant = 3'b010;
        end else if (req_valid_in[2]) begin
            grant = 3'b100;
        end
        if (grant[1]) begin
            rr_d = RR_OPPONENT;
        end else if (grant[2]) begin
            rr_d = RR_PLAYER;
        end
    end

    assign req_ready_out = rst_n_in ? grant : '0;

    always_comb begin
        sel_angle = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_angle = req_angle_in[i*ANGLE_W +: ANGLE_W];
            end
        end
        // One subtraction suffices: the widest 9-bit angle (511) is below 720.
        if (sel_angle > ANGLE_W'(ANGLE_MAX)) begin
            norm_angle = sel_angle - ANGLE_W'(ANGLE_MAX + 1);
        end else begin
            norm_angle = sel_angle;
        end
        addr_d = (|grant) ? norm_angle : addr_q;
    end

    // Tag stages cover the address register plus the ROM latency.
    // The response register then captures the ROM data.
    always_comb begin
        tag_d[0] = grant;
        for (int unsigned i = 1; i <= ROM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        rsp_valid_d = tag_q[ROM_LAT];
        rsp_cos_d   = rsp_cos_q;
        rsp_sin_d   = rsp_sin_q;
        if (|tag_q[ROM_LAT]) begin
            rsp_cos_d = rom_cos_in;
            rsp_sin_d = rom_sin_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_q        <= RR_PLAYER;
            addr_q      <= '0;
            rsp_valid_q <= '0;
            rsp_cos_q   <= '0;
            rsp_sin_q   <= '0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_cos_q   <= rsp_cos_d;
            rsp_sin_q   <= rsp_sin_d;
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign rom_addr_out  = addr_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_cos_out   = rsp_cos_q;
    assign rsp_sin_out   = rsp_sin_q;

endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Self-checking bench for trig_rom_arbiter: directed scenarios plus randomized traffic.
// Expected values come from a queue-based reference model and a two-cycle ROM model.
module tb_trig_rom_arbiter;

    localparam int AW = 9;
    localparam int TW = 11;

    logic                   clk_in   = 1'b0;
    logic                   rst_n_in = 1'b1;
    logic [2:0]             req_valid_in = '0;
    logic [3*AW-1:0]        req_angle_in = '0;
    logic [2:0]             req_ready_out;
    logic [2:0]             rsp_valid_out;
    logic signed [TW-1:0]   rsp_cos_out;
    logic signed [TW-1:0]   rsp_sin_out;
    logic [AW-1:0]          rom_addr_out;
    logic signed [TW-1:0]   rom_cos_in = '0;
    logic signed [TW-1:0]   rom_sin_in = '0;

    always #5 clk_in = ~clk_in;

    trig_rom_arbiter #(
        .ANGLE_W  (AW),
        .TRIG_W   (TW),
        .ANGLE_MAX(359),
        .ROM_LAT  (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .req_valid_in (req_valid_in),
        .req_angle_in (req_angle_in),
        .req_ready_out(req_ready_out),
        .rsp_valid_out(rsp_valid_out),
        .rsp_cos_out  (rsp_cos_out),
        .rsp_sin_out  (rsp_sin_out),
        .rom_addr_out (rom_addr_out),
        .rom_cos_in   (rom_cos_in),
        .rom_sin_in   (rom_sin_in)
    );

    // External ROM: address register, then data register.
    int cos_tab [360];
    int sin_tab [360];
    logic [AW-1:0] rom_a1 = '0;
    always @(posedge clk_in) begin
        rom_a1     <= rom_addr_out;
        rom_cos_in <= TW'(cos_tab[rom_a1]);
        rom_sin_in <= TW'(sin_tab[rom_a1]);
    end

    typedef struct {
        int due;
        int tag;
        int ang;
    } ent_t;

    ent_t       q[$];
    int         m_rr, m_addr, m_cos, m_sin, cyc;
    int         n_vec, n_bad;
    logic [2:0] v_drv;
    int         ang_drv [3];
    logic [2:0] last_ready, last_rsp;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (v_drv[0]) return 0;
        if (v_drv[1] && v_drv[2]) return m_rr;
        if (v_drv[1]) return 1;
        if (v_drv[2]) return 2;
        return -1;
    endfunction

    task automatic tick(input bit rst_low);
        int         g;
        ent_t       e;
        logic [2:0] exp_ready, exp_rsp;
        rst_n_in     = !rst_low;
        req_valid_in = v_drv;
        req_angle_in = {AW'(ang_drv[2]), AW'(ang_drv[1]), AW'(ang_drv[0])};
        if (rst_low) begin
            q.delete();
            m_rr = 1; m_addr = 0; m_cos = 0; m_sin = 0;
        end
        #1;
        g         = rst_low ? -1 : model_grant();
        exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        last_ready = req_ready_out;
        check_eq("req_ready", req_ready_out, exp_ready);
        @(posedge clk_in);
        cyc++;
        if (g >= 0) begin
            e.due = cyc + 3;
            e.tag = g;
            e.ang = ang_drv[g] % 360;
            q.push_back(e);
            m_addr = e.ang;
            if (g == 1) m_rr = 2;
            else if (g == 2) m_rr = 1;
        end
        @(negedge clk_in);
        exp_rsp = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e       = q.pop_front();
            exp_rsp = 3'(1 << e.tag);
            m_cos   = cos_tab[e.ang];
            m_sin   = sin_tab[e.ang];
        end
        last_rsp = rsp_valid_out;
        check_eq("rsp_valid", rsp_valid_out, exp_rsp);
        check_eq("rsp_cos", rsp_cos_out, m_cos);
        check_eq("rsp_sin", rsp_sin_out, m_sin);
        check_eq("rom_addr", rom_addr_out, m_addr);
    endtask

    initial begin
        int cnt;
        int prob [3];
        for (int a = 0; a < 360; a++) begin
            cos_tab[a] = $rtoi($floor(512.0 * $cos(a * 3.14159265358979 / 180.0) + 0.5));
            sin_tab[a] = $rtoi($floor(512.0 * $sin(a * 3.14159265358979 / 180.0) + 0.5));
        end
        n_vec = 0; n_bad = 0; cyc = 0;
        m_rr = 1; m_addr = 0; m_cos = 0; m_sin = 0;
        v_drv = '0;
        for (int i = 0; i < 3; i++) ang_drv[i] = 0;
        #2;
        tick(1); tick(1);

        // Priority and round-robin
        v_drv = 3'b111; ang_drv[0] = 0; ang_drv[1] = 45; ang_drv[2] = 180;
        tick(0); check_eq("prio_g0", last_ready, 3'b001);
        tick(0); check_eq("prio_g1", last_ready, 3'b001);
        v_drv = 3'b110;
        tick(0); check_eq("rr_g0", last_ready, 3'b010);
        tick(0); check_eq("rr_g1", last_ready, 3'b100);
        tick(0); check_eq("rr_g2", last_ready, 3'b010);
        tick(0); check_eq("rr_g3", last_ready, 3'b100);
        v_drv = '0;
        repeat (4) tick(0);

        // Single request after reset
        tick(1);
        v_drv = 3'b010; ang_drv[1] = 90;
        tick(0); check_eq("single_addr", rom_addr_out, 90);
        v_drv = '0;
        tick(0); check_eq("single_early0", last_rsp, 3'b000);
        tick(0); check_eq("single_early1", last_rsp, 3'b000);
        tick(0);
        check_eq("single_rsp", last_rsp, 3'b010);
        check_eq("single_cos", rsp_cos_out, 0);
        check_eq("single_sin", rsp_sin_out, 512);
        tick(0); check_eq("single_once", last_rsp, 3'b000);

        // Wrap
        v_drv = 3'b100;
        ang_drv[2] = 400; tick(0); check_eq("wrap_400", rom_addr_out, 40);
        ang_drv[2] = 359; tick(0); check_eq("wrap_359", rom_addr_out, 359);
        ang_drv[2] = 511; tick(0); check_eq("wrap_511", rom_addr_out, 151);
        v_drv = '0;
        repeat (4) tick(0);

        // Pipelining
        v_drv = 3'b010; ang_drv[1] = 10; tick(0);
        v_drv = 3'b100; ang_drv[2] = 20; tick(0);
        v_drv = 3'b010; ang_drv[1] = 30; tick(0);
        v_drv = '0;
        tick(0); check_eq("pipe_r0", last_rsp, 3'b010);
        tick(0); check_eq("pipe_r1", last_rsp, 3'b100);
        tick(0); check_eq("pipe_r2", last_rsp, 3'b010);
        tick(0);

        // Reset mid-flight
        v_drv = 3'b010; ang_drv[1] = 100; tick(0);
        v_drv = 3'b100; ang_drv[2] = 200; tick(0);
        v_drv = '0;
        tick(1);
        check_eq("rst_addr", rom_addr_out, 0);
        check_eq("rst_cos", rsp_cos_out, 0);
        check_eq("rst_sin", rsp_sin_out, 0);
        cnt = 0;
        repeat (10) begin
            tick(0);
            if (last_rsp != 3'b000) cnt++;
        end
        check_eq("rst_no_rsp", cnt, 0);
        v_drv = 3'b110; ang_drv[1] = 5; ang_drv[2] = 6;
        tick(0); check_eq("rst_rr_first", last_ready, 3'b010);
        v_drv = '0;
        repeat (4) tick(0);

        // Idle hold
        v_drv = 3'b010; ang_drv[1] = 270; tick(0);
        v_drv = '0;
        cnt = 0;
        repeat (20) begin
            tick(0);
            if (last_rsp != 3'b000) cnt++;
            check_eq("idle_addr", rom_addr_out, 270);
            check_eq("idle_ready", last_ready, 3'b000);
        end
        check_eq("idle_rsp_count", cnt, 1);

        // Randomized traffic with held-until-accepted requests
        prob[0] = 15; prob[1] = 50; prob[2] = 50;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v_drv[i] && $urandom_range(0, 99) < prob[i]) begin
                    v_drv[i]   = 1'b1;
                    ang_drv[i] = $urandom_range(0, 511);
                end
            end
            tick($urandom_range(0, 199) == 0);
            for (int i = 0; i < 3; i++) begin
                if (last_ready[i]) v_drv[i] = 1'b0;
            end
        end
        v_drv = '0;
        repeat (5) tick(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
